// File: rtl/ppg_pkg.sv
// ppg_pkg: shared definitions for the PPG window feeder slice.
//   DATA_W, N_SAMPLES : sample width and window depth fed to the CO core
//   sample_t          : one signed PPG sample / core result
//   window_t          : one full inference window, index 0 is the oldest sample
//   feeder_state_e    : feeder control states
package ppg_pkg;

  localparam int DATA_W    = 16;
  localparam int N_SAMPLES = 24;
  localparam int IDX_W     = $clog2(N_SAMPLES);

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef sample_t window_t [0:N_SAMPLES-1];

  typedef enum logic [1:0] {
    FILL,
    ARM,
    WAIT,
    OUT
  } feeder_state_e;

endpackage

// File: rtl/ppg_window_feeder_if.sv
// ppg_window_feeder_if: bundles the three handshakes around the feeder.
//   sample stream : s_valid, s_data (to feeder), s_ready (from feeder)
//   core side     : win_data, nn_start (to core), nn_done, nn_result (from core)
//   result stream : m_valid, m_data (from feeder), m_ready (to feeder)
//   status        : busy, timeout_err (from feeder)
// master = the feeder's view, slave = the environment's view.
interface ppg_window_feeder_if;
  import ppg_pkg::*;

  logic    s_valid;
  sample_t s_data;
  logic    s_ready;

  window_t win_data;
  logic    nn_start;
  logic    nn_done;
  sample_t nn_result;

  logic    m_valid;
  sample_t m_data;
  logic    m_ready;

  logic    busy;
  logic    timeout_err;

  modport master (
    input  s_valid, s_data, nn_done, nn_result, m_ready,
    output s_ready, win_data, nn_start, m_valid, m_data, busy, timeout_err
  );

  modport slave (
    output s_valid, s_data, nn_done, nn_result, m_ready,
    input  s_ready, win_data, nn_start, m_valid, m_data, busy, timeout_err
  );

endinterface

// File: rtl/ppg_window_buf.sv
// ppg_window_buf: N_SAMPLES-deep sample register file with a wrapping write
// index. Samples land in arrival order, so entry 0 is always the oldest.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   i_wr_en    : write i_wr_data at the current index this cycle
//   i_wr_data  : sample to store
//   o_win      : full window contents, stable whenever i_wr_en is low
//   o_full     : this cycle's write fills the last slot (index wraps to 0)
module ppg_window_buf
  import ppg_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    i_wr_en,
  input  sample_t i_wr_data,
  output window_t o_win,
  output logic    o_full
);

  window_t          r_win;
  logic [IDX_W-1:0] r_wr_idx;
  logic             w_last;

  assign w_last = i_wr_en && (r_wr_idx == IDX_W'(N_SAMPLES - 1));

  // Store each accepted sample and advance the index, wrapping after the
  // final slot so the next window starts again at entry 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        r_win[i] <= '0;
      end
      r_wr_idx <= '0;
    end else if (i_wr_en) begin
      r_win[r_wr_idx] <= i_wr_data;
      r_wr_idx        <= w_last ? '0 : r_wr_idx + IDX_W'(1);
    end
  end

  assign o_win  = r_win;
  assign o_full = w_last;

endmodule

// File: rtl/ppg_window_feeder.sv
// ppg_window_feeder: collects PPG samples into windows, runs the CO core's
// start/done handshake on each window and returns the core result as a
// valid/ready stream.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   bus        : ppg_window_feeder_if.master (sample in, core, result out,
//                busy and sticky timeout_err status)
// Parameter TIMEOUT_CYCLES bounds the time spent waiting for the core.
module ppg_window_feeder
  import ppg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
)
(
  input  logic                 clk,
  input  logic                 reset,
  ppg_window_feeder_if.master  bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  feeder_state_e    r_state;
  feeder_state_e    w_next_state;
  logic [CNT_W-1:0] r_tmo_cnt;
  sample_t          r_m_data;
  logic             r_timeout_err;

  logic             w_s_ready;
  logic             w_nn_start;
  logic             w_m_valid;
  logic             w_accept;
  logic             w_win_full;
  logic             w_tmo_hit;
  logic             w_capture;
  logic             w_timeout;
  window_t          w_win;

  ppg_window_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_accept),
    .i_wr_data (bus.s_data),
    .o_win     (w_win),
    .o_full    (w_win_full)
  );

  assign w_accept  = w_s_ready && bus.s_valid;
  assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // Done takes priority over an expiring timeout on the same cycle.
  assign w_capture = (r_state == WAIT) && bus.nn_done;
  assign w_timeout = (r_state == WAIT) && !bus.nn_done && w_tmo_hit;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and per-state outputs. ARM holds off until the core's done
  // level from the previous window has dropped, which also guarantees at
  // least one low cycle of nn_start between windows.
  always_comb begin
    w_next_state = r_state;
    w_s_ready    = 1'b0;
    w_nn_start   = 1'b0;
    w_m_valid    = 1'b0;
    case (r_state)
      FILL: begin
        w_s_ready = 1'b1;
        if (w_win_full) begin
          w_next_state = ARM;
        end
      end
      ARM: begin
        if (!bus.nn_done) begin
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        w_nn_start = 1'b1;
        if (w_capture) begin
          w_next_state = OUT;
        end else if (w_timeout) begin
          w_next_state = FILL;
        end
      end
      OUT: begin
        w_m_valid = 1'b1;
        if (bus.m_ready) begin
          w_next_state = FILL;
        end
      end
      default: begin
        w_next_state = FILL;
      end
    endcase
  end

  // Cycles spent in WAIT; cleared in every other state so each window
  // starts its timeout budget from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  // Result register: loaded once when done is seen, then held through OUT
  // until the downstream handshake completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m_data <= '0;
    end else if (w_capture) begin
      r_m_data <= bus.nn_result;
    end
  end

  // Sticky abandon flag; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign bus.s_ready     = w_s_ready;
  assign bus.nn_start    = w_nn_start;
  assign bus.m_valid     = w_m_valid;
  assign bus.m_data      = r_m_data;
  assign bus.win_data    = w_win;
  assign bus.busy        = (r_state != FILL);
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ppg_window_feeder.sv
// tb_ppg_window_feeder: randomized scoreboard bench for ppg_window_feeder.
// Stimulus pushes each issued sample and each expected result into queues;
// a negedge monitor pops and compares when the DUT starts the core or
// hands over a result. A queue-driven core model answers each window.
module tb_ppg_window_feeder;
  import ppg_pkg::*;

  localparam int TMO   = 4096;
  localparam int LIMIT = 6000;

  typedef struct {
    int      delay;
    bit      hang;
    sample_t res;
  } core_job_t;

  logic clk;
  logic reset;

  ppg_window_feeder_if bus();

  ppg_window_feeder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int        total = 0;
  int        bad = 0;
  sample_t   expWinQ[$];
  sample_t   expResQ[$];
  core_job_t coreQ[$];
  bit        coreHoldDone = 0;
  bit        rndReady = 0;
  bit        mReadyHold = 1;
  int        startRises = 0;

  core_job_t coreCur;
  bit        coreActive = 0;
  int        coreCnt = 0;

  logic      prevStart = 0;
  logic      prevMvalid = 0;
  logic      prevHs = 0;
  sample_t   prevMdata = '0;
  sample_t   expSample;

  sample_t   winBuf [N_SAMPLES];
  int        plan [N_SAMPLES] = '{733, 2461, 1358, 1243, 4178, 4178, 2932, 1319,
                                  1554, 4802, 2862, 79, 587, 1611, 2297, 1246,
                                  1168, 2916, 1463, 1940, 1168, 2192, 801, 322};
  int        n;
  int        startsBefore;
  sample_t   firstNew;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Offers one sample after an optional idle gap and returns once accepted.
  task automatic applyStimulus(input sample_t v, input int gap);
    int waited;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = v;
    expWinQ.push_back(v);
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.s_ready) break;
      waited++;
      if (waited > LIMIT) begin
        total++;
        bad++;
        $display("[TB] FAIL s_ready_wait: actual=no accept required=accept within %0d cycles", LIMIT);
        break;
      end
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  // Queues the core's answer (and the expected result unless the core
  // will hang), then streams winBuf.
  task automatic sendWindow(input int delay, input bit hang, input sample_t res, input int maxGap);
    core_job_t job;
    job.delay = delay;
    job.hang  = hang;
    job.res   = res;
    coreQ.push_back(job);
    if (!hang) expResQ.push_back(res);
    for (int i = 0; i < N_SAMPLES; i++) begin
      applyStimulus(winBuf[i], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
    end
  endtask

  task automatic randWindow();
    for (int i = 0; i < N_SAMPLES; i++) begin
      winBuf[i] = sample_t'($urandom);
    end
  endtask

  task automatic idleCycles(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    while ((expResQ.size() != 0 || bus.busy) && k < LIMIT) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("drain_in_time", int'(k < LIMIT), 1);
  endtask

  // Downstream ready: fixed level or random per cycle.
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.m_ready = rndReady ? 1'($urandom_range(0, 1)) : mReadyHold;
    end
  end

  // Core model: takes the next job when nn_start rises, raises done after
  // the job's delay, drops done once nn_start falls unless told to hold it.
  initial begin
    bus.nn_done   = 1'b0;
    bus.nn_result = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        coreActive  = 0;
        coreCnt     = 0;
        bus.nn_done = 1'b0;
      end else begin
        if (coreActive && !bus.nn_start) coreActive = 0;
        if (!coreActive && bus.nn_start && !bus.nn_done) begin
          if (coreQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL core_job: actual=no job queued required=one job per window");
          end else begin
            coreCur    = coreQ.pop_front();
            coreActive = 1;
            coreCnt    = 0;
          end
        end
        if (coreActive && !coreCur.hang) begin
          coreCnt++;
          if (coreCnt >= coreCur.delay) begin
            bus.nn_done   = 1'b1;
            bus.nn_result = coreCur.res;
            coreActive    = 0;
          end
        end
        if (!bus.nn_start && bus.nn_done && !coreHoldDone) bus.nn_done = 1'b0;
      end
    end
  end

  // Monitor: window check at each nn_start rise, result check at each
  // handshake, and m_valid/m_data stability while a result is pending.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (bus.nn_start && !prevStart) begin
          startRises++;
          if (expWinQ.size() < N_SAMPLES) begin
            total++;
            bad++;
            $display("[TB] FAIL window_count: actual=%0d queued required=%0d", expWinQ.size(), N_SAMPLES);
            expWinQ.delete();
          end else begin
            for (int i = 0; i < N_SAMPLES; i++) begin
              expSample = expWinQ.pop_front();
              checkOutput($sformatf("win_data[%0d]", i), int'(bus.win_data[i]), int'(expSample));
            end
          end
        end
        if (prevMvalid && !prevHs) begin
          checkOutput("m_valid_held", int'(bus.m_valid), 1);
          checkOutput("m_data_held", int'(bus.m_data), int'(prevMdata));
        end
        if (bus.m_valid && bus.m_ready) begin
          if (expResQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL result_count: actual=unexpected result %0d required=none", bus.m_data);
          end else begin
            expSample = expResQ.pop_front();
            checkOutput("m_data", int'(bus.m_data), int'(expSample));
          end
        end
        prevStart  = bus.nn_start;
        prevMvalid = bus.m_valid;
        prevHs     = bus.m_valid && bus.m_ready;
        prevMdata  = bus.m_data;
      end else begin
        prevStart  = 1'b0;
        prevMvalid = 1'b0;
        prevHs     = 1'b0;
      end
    end
  end

  // Watchdog against an unbounded run.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_nn_start", int'(bus.nn_start), 0);
    checkOutput("rst_m_valid", int'(bus.m_valid), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_s_ready", int'(bus.s_ready), 1);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_m_data", int'(bus.m_data), 0);
    checkOutput("rst_timeout_err", int'(bus.timeout_err), 0);
    checkOutput("rst_win0", int'(bus.win_data[0]), 0);
    checkOutput("rst_win23", int'(bus.win_data[23]), 0);

    // Fixed window, start latency, then a slow core returning -1234.
    for (int i = 0; i < N_SAMPLES; i++) winBuf[i] = sample_t'(plan[i]);
    mReadyHold = 1;
    sendWindow(300, 0, -16'sd1234, 0);
    checkOutput("t1_s_ready_after_last", int'(bus.s_ready), 0);
    checkOutput("t1_nn_start_early", int'(bus.nn_start), 0);
    @(posedge clk); #1;
    checkOutput("t1_nn_start_2cyc", int'(bus.nn_start), 1);
    checkOutput("t1_win0", int'(bus.win_data[0]), 733);
    checkOutput("t1_win23", int'(bus.win_data[23]), 322);
    n = 0;
    while (!bus.nn_done && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t2_done_seen", int'(n < LIMIT), 1);
    checkOutput("t2_m_valid_1cyc", int'(bus.m_valid), 1);
    checkOutput("t2_m_data", int'(bus.m_data), -1234);
    checkOutput("t2_nn_start_low", int'(bus.nn_start), 0);
    @(posedge clk); #1;
    checkOutput("t2_s_ready_back", int'(bus.s_ready), 1);
    checkOutput("t2_busy_low", int'(bus.busy), 0);

    // Result held under 50 cycles of backpressure.
    mReadyHold = 0;
    randWindow();
    sendWindow(5, 0, -16'sd1234, 1);
    n = 0;
    while (!bus.m_valid && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t3_m_valid_seen", int'(n < LIMIT), 1);
    startsBefore = startRises;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (c % 10 == 9) begin
        checkOutput("t3_m_valid", int'(bus.m_valid), 1);
        checkOutput("t3_m_data", int'(bus.m_data), -1234);
        checkOutput("t3_s_ready", int'(bus.s_ready), 0);
        checkOutput("t3_no_restart", startRises, startsBefore);
      end
    end
    mReadyHold = 1;
    waitIdle();

    // Core never answers: window abandoned after TMO cycles in WAIT.
    randWindow();
    sendWindow(0, 1, '0, 0);
    @(posedge clk); #1;
    checkOutput("t4_nn_start", int'(bus.nn_start), 1);
    n = 0;
    while (bus.nn_start && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t4_wait_cycles", n, TMO);
    checkOutput("t4_timeout_err", int'(bus.timeout_err), 1);
    checkOutput("t4_m_valid", int'(bus.m_valid), 0);
    checkOutput("t4_busy", int'(bus.busy), 0);
    randWindow();
    sendWindow(10, 0, sample_t'($urandom), 0);
    waitIdle();
    checkOutput("t4_err_sticky", int'(bus.timeout_err), 1);

    // Done held high across windows: feeder must stall in ARM.
    coreHoldDone = 1;
    randWindow();
    sendWindow(20, 0, sample_t'($urandom), 0);
    waitIdle();
    randWindow();
    sendWindow(15, 0, sample_t'($urandom), 0);
    startsBefore = startRises;
    idleCycles(20);
    checkOutput("t5_stall_nn_start", int'(bus.nn_start), 0);
    checkOutput("t5_stall_busy", int'(bus.busy), 1);
    checkOutput("t5_stall_s_ready", int'(bus.s_ready), 0);
    checkOutput("t5_stall_no_start", startRises, startsBefore);
    coreHoldDone = 0;
    waitIdle();
    checkOutput("t5_one_start", startRises, startsBefore + 1);

    // Random windows, gaps, delays and downstream backpressure.
    rndReady = 1;
    repeat (6) begin
      randWindow();
      sendWindow(int'($urandom_range(1, 40)), 0, sample_t'($urandom), 2);
    end
    waitIdle();
    rndReady = 0;
    mReadyHold = 1;

    // Asynchronous reset mid-WAIT, then a fresh window.
    randWindow();
    sendWindow(0, 1, '0, 0);
    idleCycles(100);
    checkOutput("t6_in_wait", int'(bus.nn_start), 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_async_nn_start", int'(bus.nn_start), 0);
    checkOutput("t6_async_m_valid", int'(bus.m_valid), 0);
    checkOutput("t6_async_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    checkOutput("t6_err_cleared", int'(bus.timeout_err), 0);
    checkOutput("t6_win_cleared", int'(bus.win_data[0]), 0);
    expWinQ.delete();
    expResQ.delete();
    coreQ.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    randWindow();
    firstNew = winBuf[0];
    sendWindow(7, 0, sample_t'($urandom), 0);
    checkOutput("t6_win0_fresh", int'(bus.win_data[0]), int'(firstNew));
    waitIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
